// File: rtl/axis_event_packer.sv
// axis_event_packer: buffers 128-bit detector events {time, pattern} in a FIFO
// and serialises each one as four 32-bit AXI4-Stream words, pattern low word
// first. The upstream stage cannot be stalled, so events arriving while the FIFO
// is full are dropped and flagged on sts_overflow.
// Optional build macro DROP_CNTR_EN adds the saturating 32-bit sts_drops counter.
module axis_event_packer #(
   parameter int FIFO_ADDR_WIDTH = 4
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [127:0]               s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic [31:0]                m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [FIFO_ADDR_WIDTH:0]   sts_level,
   output logic                       sts_overflow
`ifdef DROP_CNTR_EN
   ,
   output logic [31:0]                sts_drops
`endif
);

   localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
   localparam logic [FIFO_ADDR_WIDTH:0]   LVL_FULL = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
   localparam logic [FIFO_ADDR_WIDTH:0]   LVL_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
   localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = FIFO_ADDR_WIDTH'(1);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t                      state_reg, state_next;
   logic [127:0]                mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_ADDR_WIDTH:0]    level_reg, level_next;
   logic [1:0]                  index_reg, index_next;
   logic [127:0]                outreg_reg;
   logic [31:0]                 tdata_reg;
   logic                        tlast_reg;
   logic                        tvalid_reg;
   logic                        overflow_reg;
   logic                        full, empty, push, pop, handshake;
   logic [31:0]                 out_words [4];

   // Split the held event into its four output words (word 0 = pattern[31:0]).
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_words
         assign out_words[gi] = outreg_reg[32*gi +: 32];
      end
   endgenerate

   // Full/empty come from the registered level only, so a pop in the same
   // cycle never rescues a strobe that hits a full FIFO.
   assign full      = (level_reg == LVL_FULL);
   assign empty     = (level_reg == '0);
   assign push      = s_axis_tvalid && !full;
   assign handshake = tvalid_reg && m_axis_tready;

   // Output FSM next-state: pop a new event when idle, or right after the
   // last word of the current one so consecutive events have no bubble.
   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      pop        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               index_next = 2'd0;
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (handshake) begin
               if (index_reg != 2'd3) begin
                  index_next = index_reg + 2'd1;
               end else if (!empty) begin
                  pop        = 1'b1;
                  index_next = 2'd0;
               end else begin
                  index_next = 2'd0;
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            index_next = 2'd0;
         end
      endcase
   end

   // Level bookkeeping: simultaneous push and pop cancel out.
   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + LVL_ONE;
         2'b01:   level_next = level_reg - LVL_ONE;
         default: level_next = level_reg;
      endcase
   end

   // Event storage; no reset so it maps onto block RAM.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem[wr_ptr_reg] <= s_axis_tdata;
      end
   end

   // FIFO pointers, level and FSM state registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         state_reg  <= ST_IDLE;
         index_reg  <= 2'd0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         level_reg <= level_next;
         state_reg <= state_next;
         index_reg <= index_next;
      end
   end

   // Registered output stage: load the head event on pop, step to the next
   // word on each accepted word, hold everything while stalled.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         outreg_reg <= '0;
         tdata_reg  <= '0;
         tlast_reg  <= 1'b0;
         tvalid_reg <= 1'b0;
      end else begin
         tvalid_reg <= (state_next == ST_SEND);
         if (pop) begin
            outreg_reg <= mem[rd_ptr_reg];
            tdata_reg  <= mem[rd_ptr_reg][31:0];
            tlast_reg  <= 1'b0;
         end else if (handshake && (index_reg != 2'd3)) begin
            tdata_reg <= out_words[index_next];
            tlast_reg <= (index_next == 2'd3);
         end
      end
   end

   // Sticky loss flag: any strobe that finds the FIFO full.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_reg <= 1'b0;
      end else if (s_axis_tvalid && full) begin
         overflow_reg <= 1'b1;
      end
   end

`ifdef DROP_CNTR_EN
   logic [31:0] drops_reg;

   // Saturating count of dropped strobes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         drops_reg <= '0;
      end else if (s_axis_tvalid && full && (drops_reg != 32'hFFFF_FFFF)) begin
         drops_reg <= drops_reg + 32'd1;
      end
   end

   assign sts_drops = drops_reg;
`endif

   assign m_axis_tdata  = tdata_reg;
   assign m_axis_tvalid = tvalid_reg;
   assign m_axis_tlast  = tlast_reg;
   assign sts_level     = level_reg;
   assign sts_overflow  = overflow_reg;

endmodule

// File: tb/tb_axis_event_packer.sv
// Directed bench for axis_event_packer: reset, single event, backpressure,
// back-to-back events, overflow with drain order, full FIFO with simultaneous
// pop, and asynchronous reset in the middle of an event.
module tb_axis_event_packer;

   localparam int AW = 4;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [127:0]  s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic [31:0]   m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic [AW:0]   sts_level;
   logic          sts_overflow;
`ifdef DROP_CNTR_EN
   logic [31:0]   sts_drops;
`endif

   int errors = 0;
   int checks = 0;
   int peak   = 0;

   axis_event_packer #(.FIFO_ADDR_WIDTH(AW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .sts_level     (sts_level),
      .sts_overflow  (sts_overflow)
`ifdef DROP_CNTR_EN
      ,
      .sts_drops     (sts_drops)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge aclk);
      #1;
   endtask

   // Check the currently presented word, then advance one clock.
   task automatic expect_word(input string tag, input logic [31:0] w, input logic last);
      check({tag, " tvalid"}, 64'(m_axis_tvalid), 64'd1);
      check({tag, " tdata"},  64'(m_axis_tdata),  64'(w));
      check({tag, " tlast"},  64'(m_axis_tlast),  64'(last));
      $display("word %s: tdata=%08h tlast=%0b level=%0d", tag, m_axis_tdata, m_axis_tlast, sts_level);
      if (int'(sts_level) > peak) peak = int'(sts_level);
      cycle();
   endtask

   // Test event k: time = {C000_0000|k, 0000_1000+k}, pattern = {B000_0000|k, A000_0000|k}.
   function automatic logic [127:0] mk_event(input int k);
      logic [31:0] kk;
      kk = 32'(k);
      return {32'hC000_0000 | kk, 32'h0000_1000 + kk, 32'hB000_0000 | kk, 32'hA000_0000 | kk};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ev;
      int           vcount;

      // ---------------- reset state
      repeat (3) cycle();
      check("rst tvalid",   64'(m_axis_tvalid), 64'd0);
      check("rst tlast",    64'(m_axis_tlast),  64'd0);
      check("rst tdata",    64'(m_axis_tdata),  64'd0);
      check("rst level",    64'(sts_level),     64'd0);
      check("rst overflow", 64'(sts_overflow),  64'd0);
`ifdef DROP_CNTR_EN
      check("rst drops",    64'(sts_drops),     64'd0);
`endif
      aresetn = 1'b1;
      cycle();

      // ---------------- single event, latency t+2
      m_axis_tready = 1'b1;
      s_axis_tdata  = {64'h0000000A_00000005, 64'h80000000_00000001};
      s_axis_tvalid = 1'b1;
      cycle();
      s_axis_tvalid = 1'b0;
      check("single t+1 tvalid", 64'(m_axis_tvalid), 64'd0);
      check("single t+1 level",  64'(sts_level),     64'd1);
      cycle();
      expect_word("single w0", 32'h00000001, 1'b0);
      expect_word("single w1", 32'h80000000, 1'b0);
      expect_word("single w2", 32'h00000005, 1'b0);
      expect_word("single w3", 32'h0000000A, 1'b1);
      check("single after tvalid", 64'(m_axis_tvalid), 64'd0);
      check("single after level",  64'(sts_level),     64'd0);

      // ---------------- backpressure on word 1 for 10 cycles
      s_axis_tdata  = {64'h00000004_00000003, 64'h00000002_00000001};
      s_axis_tvalid = 1'b1;
      cycle();
      s_axis_tvalid = 1'b0;
      cycle();
      expect_word("bp w0", 32'h00000001, 1'b0);
      m_axis_tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("bp hold tvalid", 64'(m_axis_tvalid), 64'd1);
         check("bp hold tdata",  64'(m_axis_tdata),  64'h00000002);
         check("bp hold tlast",  64'(m_axis_tlast),  64'd0);
         cycle();
      end
      m_axis_tready = 1'b1;
      expect_word("bp w1", 32'h00000002, 1'b0);
      expect_word("bp w2", 32'h00000003, 1'b0);
      expect_word("bp w3", 32'h00000004, 1'b1);
      check("bp after tvalid", 64'(m_axis_tvalid), 64'd0);

      // ---------------- three events back-to-back
      peak = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_event(1);
      cycle();
      s_axis_tdata  = mk_event(2);
      cycle();
      s_axis_tdata  = mk_event(3);
      for (int e = 0; e < 3; e++) begin
         ev = mk_event(e + 1);
         for (int w = 0; w < 4; w++) begin
            expect_word($sformatf("b2b e%0d w%0d", e, w), ev[32*w +: 32], (w == 3));
            s_axis_tvalid = 1'b0;
         end
      end
      check("b2b peak level", 64'(peak), 64'd2);
      check("b2b after tvalid", 64'(m_axis_tvalid), 64'd0);

      // ---------------- overflow: 20 strobes with tready low
      m_axis_tready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         s_axis_tdata  = mk_event(100 + k);
         s_axis_tvalid = 1'b1;
         cycle();
      end
      s_axis_tvalid = 1'b0;
      check("ovf level",    64'(sts_level),    64'd16);
      check("ovf overflow", 64'(sts_overflow), 64'd1);
`ifdef DROP_CNTR_EN
      check("ovf drops",    64'(sts_drops),    64'd3);
`endif
      check("ovf tvalid",   64'(m_axis_tvalid), 64'd1);
      check("ovf head",     64'(m_axis_tdata),  64'hA0000064);

      // drain 17 events; a strobe at event 0 word 3 hits a full FIFO during a pop
      m_axis_tready = 1'b1;
      for (int e = 0; e < 17; e++) begin
         ev = mk_event(100 + e);
         for (int w = 0; w < 4; w++) begin
            if (e == 0 && w == 3) begin
               check("fullpop pre level", 64'(sts_level), 64'd16);
               s_axis_tdata  = mk_event(999);
               s_axis_tvalid = 1'b1;
            end
            expect_word($sformatf("drain e%0d w%0d", e, w), ev[32*w +: 32], (w == 3));
            if (e == 0 && w == 3) begin
               s_axis_tvalid = 1'b0;
               check("fullpop level", 64'(sts_level), 64'd15);
`ifdef DROP_CNTR_EN
               check("fullpop drops", 64'(sts_drops), 64'd4);
`endif
            end
         end
      end
      check("drain after tvalid", 64'(m_axis_tvalid), 64'd0);
      check("drain after level",  64'(sts_level),     64'd0);

      // ---------------- asynchronous reset while at word index 2
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_event(200);
      cycle();
      s_axis_tdata  = mk_event(201);
      cycle();
      s_axis_tdata  = mk_event(202);
      ev = mk_event(200);
      expect_word("mid w0", ev[31:0], 1'b0);
      s_axis_tvalid = 1'b0;
      expect_word("mid w1", ev[63:32], 1'b0);
      m_axis_tready = 1'b0;
      check("mid w2 tdata", 64'(m_axis_tdata), 64'(ev[95:64]));
      check("mid level",    64'(sts_level),    64'd2);
      #3;
      aresetn = 1'b0;
      #1;
      check("arst tvalid",   64'(m_axis_tvalid), 64'd0);
      check("arst tlast",    64'(m_axis_tlast),  64'd0);
      check("arst tdata",    64'(m_axis_tdata),  64'd0);
      check("arst level",    64'(sts_level),     64'd0);
      check("arst overflow", 64'(sts_overflow),  64'd0);
`ifdef DROP_CNTR_EN
      check("arst drops",    64'(sts_drops),     64'd0);
`endif
      cycle();
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      vcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (m_axis_tvalid) vcount++;
         cycle();
      end
      check("post-reset stale words", 64'(vcount), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
